// File: rtl/cache_types_pkg.sv
// Shared cache-side types and sizes.
// Holds the bank count, block and word sizes, the RAM word address type,
// and the state encoding used by the cache-to-RAM arbiter.
package cache_types_pkg;

  localparam int NUM_BANKS     = 4;
  localparam int BLOCK_SIZE    = 4;
  localparam int CACHE_RW_SIZE = 32;

  typedef logic [31:0] addr_t;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/cache_ram_arbiter_if.sv
// Bus between the cache bank array, the arbiter and the RAM controller.
// Bank side : bank_REN/WEN/addr/store (flat per-bank vectors), bank_complete,
//             bank_load_data.
// RAM side  : ram_REN/WEN/addr/store, ram_complete, ram_load_data.
// Status    : grant_valid, grant_id, protocol_err.
// modport slave  : the arbiter.
// modport master : the surroundings (banks + RAM controller).
interface cache_ram_arbiter_if #(
  parameter int NUM_BANKS = cache_types_pkg::NUM_BANKS,
  parameter int DATA_W    = cache_types_pkg::CACHE_RW_SIZE,
  parameter int ADDR_W    = $bits(cache_types_pkg::addr_t)
);
  localparam int ID_W = $clog2(NUM_BANKS);

  logic [NUM_BANKS-1:0]        bank_REN;
  logic [NUM_BANKS-1:0]        bank_WEN;
  logic [NUM_BANKS*ADDR_W-1:0] bank_addr;
  logic [NUM_BANKS*DATA_W-1:0] bank_store;
  logic [NUM_BANKS-1:0]        bank_complete;
  logic [DATA_W-1:0]           bank_load_data;

  logic                        ram_REN;
  logic                        ram_WEN;
  logic [ADDR_W-1:0]           ram_addr;
  logic [DATA_W-1:0]           ram_store;
  logic                        ram_complete;
  logic [DATA_W-1:0]           ram_load_data;

  logic                        grant_valid;
  logic [ID_W-1:0]             grant_id;
  logic                        protocol_err;

  modport slave (
    input  bank_REN, bank_WEN, bank_addr, bank_store, ram_complete, ram_load_data,
    output bank_complete, bank_load_data, ram_REN, ram_WEN, ram_addr, ram_store,
    output grant_valid, grant_id, protocol_err
  );

  modport master (
    output bank_REN, bank_WEN, bank_addr, bank_store, ram_complete, ram_load_data,
    input  bank_complete, bank_load_data, ram_REN, ram_WEN, ram_addr, ram_store,
    input  grant_valid, grant_id, protocol_err
  );

endinterface

// File: rtl/cache_ram_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Ports:
//   req     in  N     request vector
//   rr_ptr  in  ID_W  highest-priority index this round
//   winner  out ID_W  first requesting index at or after rr_ptr (wrapping)
//   any_req out 1     at least one request present
// N must be a power of two so the index sum wraps for free.
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] rr_ptr,
  output logic [ID_W-1:0] winner,
  output logic            any_req
);

  logic [ID_W-1:0] idx;
  logic            found;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < N; i++) begin
      idx = rr_ptr + ID_W'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/cache_ram_arbiter.sv
// cache_ram_arbiter: shares one RAM word port between NUM_BANKS cache banks.
// A bank keeps the grant for up to BURST_LEN completed words (one block) so a
// block pull/eject is never interleaved with another bank's traffic.
// Ports:
//   CLK   in  clock
//   nRST  in  synchronous reset, active high
//   bus   cache_ram_arbiter_if.slave  (bank, RAM and status signals)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ARB_IDLE  | no owner; ram_* held at 0; arbitrate among requesters
// ARB_GRANT | bank grant_id owns the RAM port; its requests pass through
module cache_ram_arbiter #(
  parameter int NUM_BANKS = cache_types_pkg::NUM_BANKS,
  parameter int BURST_LEN = cache_types_pkg::BLOCK_SIZE,
  parameter int DATA_W    = cache_types_pkg::CACHE_RW_SIZE,
  parameter int ADDR_W    = $bits(cache_types_pkg::addr_t)
) (
  input logic                 CLK,
  input logic                 nRST,
  cache_ram_arbiter_if.slave  bus
);
  import cache_types_pkg::arb_state_t;
  import cache_types_pkg::ARB_IDLE;
  import cache_types_pkg::ARB_GRANT;

  localparam int ID_W  = $clog2(NUM_BANKS);
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  arb_state_t           state;
  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      grant_id_q;
  logic [CNT_W-1:0]     burst_cnt;
  logic                 protocol_err_q;

  logic [NUM_BANKS-1:0] req;
  logic [ID_W-1:0]      winner;
  logic                 any_req;

  logic                 g_ren;
  logic                 g_wen;
  logic [ADDR_W-1:0]    g_addr;
  logic [DATA_W-1:0]    g_store;
  logic                 drive_en;
  logic [NUM_BANKS-1:0] cpl_vec;

  assign req = bus.bank_REN | bus.bank_WEN;

  rr_pick #(.N(NUM_BANKS), .ID_W(ID_W)) u_pick (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  // Select the granted bank's request fields.
  always_comb begin
    g_ren   = 1'b0;
    g_wen   = 1'b0;
    g_addr  = '0;
    g_store = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (grant_id_q == ID_W'(i)) begin
        g_ren   = bus.bank_REN[i];
        g_wen   = bus.bank_WEN[i];
        g_addr  = bus.bank_addr[i*ADDR_W +: ADDR_W];
        g_store = bus.bank_store[i*DATA_W +: DATA_W];
      end
    end
  end

  // Reset is gated in so a word aborted by reset never strobes RAM or
  // reports completion in the reset cycle itself.
  assign drive_en = (state == ARB_GRANT) && !nRST;

  always_comb begin
    cpl_vec = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      cpl_vec[i] = drive_en && bus.ram_complete && (grant_id_q == ID_W'(i));
    end
  end

  // WEN wins when a bank illegally asserts both strobes.
  assign bus.ram_WEN        = drive_en && g_wen;
  assign bus.ram_REN        = drive_en && g_ren && !g_wen;
  assign bus.ram_addr       = drive_en ? g_addr  : '0;
  assign bus.ram_store      = drive_en ? g_store : '0;
  assign bus.bank_complete  = cpl_vec;
  assign bus.bank_load_data = bus.ram_load_data;

  assign bus.grant_valid    = (state == ARB_GRANT);
  assign bus.grant_id       = grant_id_q;
  assign bus.protocol_err   = protocol_err_q;

  always_ff @(posedge CLK) begin
    if (nRST) begin
      state          <= ARB_IDLE;
      rr_ptr         <= '0;
      burst_cnt      <= '0;
      grant_id_q     <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            grant_id_q <= winner;
            burst_cnt  <= '0;
            state      <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (g_ren && g_wen) protocol_err_q <= 1'b1;
          // A drop in the same cycle as ram_complete is a normal completion.
          if (bus.ram_complete) begin
            if (burst_cnt == LAST_BEAT) begin
              rr_ptr    <= grant_id_q + ID_W'(1);
              burst_cnt <= '0;
              state     <= ARB_IDLE;
            end else begin
              burst_cnt <= burst_cnt + CNT_W'(1);
            end
          end else if (!g_ren && !g_wen) begin
            rr_ptr    <= grant_id_q + ID_W'(1);
            burst_cnt <= '0;
            state     <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
